seq_divider: RTL and testbench

- Multi-cycle unsigned restoring divider: the subtract-and-shift counterpart to the combinational adder datapath.
- Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Uses a start/busy/done handshake and sits beside the ALU as a slow-path unit for a later divide extension.

---
 rtl/div_pkg.sv | 12 +
 rtl/div_step.sv | 32 +++
 rtl/seq_divider.sv | 99 +++++++++
 tb/tb_seq_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: default operand width and FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, and keep the difference only if it did not go negative.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] q_next
);

  // The partial remainder is always below the divisor, so it fits in WIDTH bits;
  // only the shifted and trial values need the extra bit.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    shifted = {acc, q[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      acc_next = trial[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = shifted[WIDTH-1:0];
      q_next   = {q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider with a start/busy/done handshake,
// producing one quotient bit per clock.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_t       state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] divisor_reg;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .q        (q),
    .divisor  (divisor_reg),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  // Results are written on the edge that enters DONE so they are valid alongside done
  // and then held untouched until a later operation finishes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      acc         <= '0;
      q           <= '0;
      divisor_reg <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (divisor != '0) begin
              divisor_reg <= divisor;
              acc         <= '0;
              q           <= dividend;
              cnt         <= CNT_W'(WIDTH - 1);
              div_by_zero <= 1'b0;
              busy        <= 1'b1;
              state       <= S_RUN;
            end else begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              done        <= 1'b1;
              state       <= S_DONE;
            end
          end
        end
        S_RUN: begin
          acc <= acc_next;
          q   <= q_next;
          if (cnt == '0) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= acc_next;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: handshake timing, divide-by-zero, ignored starts,
// mid-run reset, a full 4-bit sweep, and a few hand-worked single iterations of div_step.
module tb_seq_divider;
  import div_pkg::*;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  logic [3:0] step_acc;
  logic [3:0] step_q;
  logic [3:0] step_div;
  logic [3:0] step_acc_next;
  logic [3:0] step_q_next;

  int tests_run    = 0;
  int tests_failed = 0;

  seq_divider #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  div_step #(.WIDTH(4)) ref_step (
    .acc      (step_acc),
    .q        (step_q),
    .divisor  (step_div),
    .acc_next (step_acc_next),
    .q_next   (step_q_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Presents an operation for one edge; returns at the falling edge after the accepting edge.
  task automatic apply_stimulus(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int edges, output int busy_cycles);
    bit overlap;
    overlap     = busy && done;
    edges       = 1;
    busy_cycles = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (busy) busy_cycles++;
      @(negedge clk);
      edges++;
      if (busy && done) overlap = 1'b1;
    end
    check_output({tag, " done seen"}, 32'(done), 32'd1);
    check_output({tag, " busy+done"}, 32'(overlap), 32'd0);
  endtask

  task automatic run_and_check(input string tag, input logic [3:0] a, input logic [3:0] b,
                               input logic [3:0] exp_q, input logic [3:0] exp_r,
                               input logic exp_dbz, input int exp_edges, input int exp_busy);
    int edges;
    int busy_cycles;
    apply_stimulus(a, b);
    wait_done(tag, edges, busy_cycles);
    check_output({tag, " latency"}, 32'(edges), 32'(exp_edges));
    check_output({tag, " busy cycles"}, 32'(busy_cycles), 32'(exp_busy));
    check_output({tag, " quotient"}, 32'(quotient), 32'(exp_q));
    check_output({tag, " remainder"}, 32'(remainder), 32'(exp_r));
    check_output({tag, " div_by_zero"}, 32'(div_by_zero), 32'(exp_dbz));
  endtask

  initial begin
    int edges;
    int busy_cycles;
    int extra;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    step_acc = 4'b0000; step_q = 4'b1101; step_div = 4'd3;
    #1;
    check_output("step 0/1101/3 acc", 32'(step_acc_next), 32'h1);
    check_output("step 0/1101/3 q", 32'(step_q_next), 32'hA);
    step_acc = 4'b0001; step_q = 4'b1010; step_div = 4'd3;
    #1;
    check_output("step 1/1010/3 acc", 32'(step_acc_next), 32'h0);
    check_output("step 1/1010/3 q", 32'(step_q_next), 32'h5);

    repeat (2) @(negedge clk);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset done", 32'(done), 32'd0);
    check_output("reset quotient", 32'(quotient), 32'd0);
    check_output("reset remainder", 32'(remainder), 32'd0);
    check_output("reset div_by_zero", 32'(div_by_zero), 32'd0);
    check_output("reset state", 32'(dut.state), 32'(S_IDLE));
    reset = 1'b0;

    run_and_check("13/3", 4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 5, 4);
    @(negedge clk);
    check_output("13/3 done pulse width", 32'(done), 32'd0);
    check_output("13/3 held quotient", 32'(quotient), 32'd4);

    run_and_check("15/1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 5, 4);
    run_and_check("3/7", 4'd3, 4'd7, 4'd0, 4'd3, 1'b0, 5, 4);

    run_and_check("9/0", 4'd9, 4'd0, 4'hF, 4'd9, 1'b1, 1, 0);
    @(negedge clk);
    check_output("9/0 held div_by_zero", 32'(div_by_zero), 32'd1);
    check_output("9/0 held quotient", 32'(quotient), 32'hF);
    check_output("9/0 done pulse width", 32'(done), 32'd0);
    run_and_check("8/2", 4'd8, 4'd2, 4'd4, 4'd0, 1'b0, 5, 4);

    apply_stimulus(4'd14, 4'd4);
    start    = 1'b1;
    dividend = 4'd5;
    divisor  = 4'd5;
    wait_done("14/4 ignore", edges, busy_cycles);
    start = 1'b0;
    check_output("14/4 ignore latency", 32'(edges), 32'd5);
    check_output("14/4 ignore busy cycles", 32'(busy_cycles), 32'd4);
    check_output("14/4 ignore quotient", 32'(quotient), 32'd3);
    check_output("14/4 ignore remainder", 32'(remainder), 32'd2);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check_output("14/4 ignore extra activity", 32'(extra), 32'd0);

    apply_stimulus(4'd11, 4'd2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_output("midrun reset busy", 32'(busy), 32'd0);
    check_output("midrun reset done", 32'(done), 32'd0);
    check_output("midrun reset quotient", 32'(quotient), 32'd0);
    check_output("midrun reset remainder", 32'(remainder), 32'd0);
    check_output("midrun reset div_by_zero", 32'(div_by_zero), 32'd0);
    check_output("midrun reset state", 32'(dut.state), 32'(S_IDLE));
    reset = 1'b0;
    extra = 0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    check_output("midrun reset no done", 32'(extra), 32'd0);
    run_and_check("11/2 after reset", 4'd11, 4'd2, 4'd5, 4'd1, 1'b0, 5, 4);

    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_and_check($sformatf("sweep %0d/%0d", a, b), 4'(a), 4'(b),
                      4'(a / b), 4'(a % b), 1'b0, 5, 4);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
